// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    ERR   = 2'd3
  } unstuff_state_t;

  localparam int USB_STUFF_RUN = 6;
  localparam int USB_BYTE_BITS = 8;

endpackage

// File: rtl/rx_shift_reg.sv
// LSB-first receive shift register: new bits enter at the MSB and move right.
module rx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next
);

  // data_next lets the owner capture a completed byte on the same edge it shifts in
  assign data_next = {bit_in, data[WIDTH-1:1]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= data_next;
    end
  end

endmodule

// File: rtl/rx_nrzi_unstuff.sv
// USB RX bit stage: samples D+/D- on the bit-timer strobe, NRZI-decodes,
// removes stuffed zeros, flags SE0 and assembles LSB-first bytes.
//
// state | meaning
// IDLE  | no packet bits seen since rcving rose
// RUN   | decoding and shifting data bits
// STUFF | a run of ones just ended; the next bit must be a stuffed 0
// ERR   | stuffing violation; strobes ignored until rcving drops
module rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int DATA_BITS = USB_BYTE_BITS,
  parameter int STUFF_RUN = USB_STUFF_RUN
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 d_plus_sync,
  input  logic                 d_minus_sync,
  input  logic                 shift_enable,
  input  logic                 rcving,
  output logic                 d_orig,
  output logic                 stuff_skip,
  output logic                 stuff_err,
  output logic                 eop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 byte_valid
);

  localparam int ONES_W = $clog2(STUFF_RUN + 1);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [ONES_W-1:0] RUN_MAX  = ONES_W'(STUFF_RUN);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  unstuff_state_t        state;
  logic                  prev_dp;
  logic [ONES_W-1:0]     ones_cnt;
  logic [ONES_W-1:0]     ones_next;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  sr_data;
  logic [DATA_BITS-1:0]  sr_next;
  logic                  se0;
  logic                  dec_bit;
  logic                  sample;
  logic                  data_shift;

  assign se0     = ~d_plus_sync & ~d_minus_sync;
  assign dec_bit = (d_plus_sync == prev_dp);
  assign sample  = shift_enable & rcving & (state != ERR);
  // Stuffed bits and SE0 never reach the shift register
  assign data_shift = sample & ~se0 & ((state == IDLE) || (state == RUN));

  always_comb begin
    ones_next = '0;
    if (dec_bit) begin
      ones_next = (ones_cnt == RUN_MAX) ? ones_cnt : ones_cnt + ONES_W'(1);
    end
  end

  rx_shift_reg #(
    .WIDTH (DATA_BITS)
  ) u_shift_reg (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (~rcving),
    .shift_en  (data_shift),
    .bit_in    (dec_bit),
    .data      (sr_data),
    .data_next (sr_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      prev_dp    <= 1'b1;
      ones_cnt   <= '0;
      bit_cnt    <= '0;
      d_orig     <= 1'b1;
      stuff_skip <= 1'b0;
      stuff_err  <= 1'b0;
      eop        <= 1'b0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
    end else begin
      stuff_skip <= 1'b0;
      stuff_err  <= 1'b0;
      byte_valid <= 1'b0;
      if (!rcving) begin
        state    <= IDLE;
        prev_dp  <= 1'b1;
        ones_cnt <= '0;
        bit_cnt  <= '0;
        eop      <= 1'b0;
      end else if (sample) begin
        if (se0) begin
          eop <= 1'b1;
          if (state == IDLE) state <= RUN;
        end else begin
          eop     <= 1'b0;
          prev_dp <= d_plus_sync;
          d_orig  <= dec_bit;
          if (state == STUFF) begin
            if (dec_bit) begin
              stuff_err <= 1'b1;
              state     <= ERR;
            end else begin
              stuff_skip <= 1'b1;
              ones_cnt   <= '0;
              state      <= RUN;
            end
          end else begin
            ones_cnt <= ones_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              rx_data    <= sr_next;
              byte_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
            state <= (ones_next == RUN_MAX) ? STUFF : RUN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
// Directed bench for rx_nrzi_unstuff: decode, bytes, stuffing, EOP, clear and reset.
`timescale 1ns/1ps
module tb_rx_nrzi_unstuff;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus_sync = 1'b1;
  logic       d_minus_sync = 1'b0;
  logic       shift_enable = 1'b0;
  logic       rcving = 1'b0;
  logic       d_orig;
  logic       stuff_skip;
  logic       stuff_err;
  logic       eop;
  logic [7:0] rx_data;
  logic       byte_valid;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  int skip_cnt = 0;
  int err_cnt = 0;
  logic line_dp = 1'b1;

  always #5 clk = ~clk;

  rx_nrzi_unstuff dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_sync  (d_plus_sync),
    .d_minus_sync (d_minus_sync),
    .shift_enable (shift_enable),
    .rcving       (rcving),
    .d_orig       (d_orig),
    .stuff_skip   (stuff_skip),
    .stuff_err    (stuff_err),
    .eop          (eop),
    .rx_data      (rx_data),
    .byte_valid   (byte_valid)
  );

  always @(negedge clk) begin
    if (byte_valid) bv_cnt++;
    if (stuff_skip) skip_cnt++;
    if (stuff_err)  err_cnt++;
  end

  task automatic strobe(input logic dp, input logic dm);
    @(negedge clk);
    d_plus_sync  = dp;
    d_minus_sync = dm;
    shift_enable = 1'b1;
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    if (!b) line_dp = ~line_dp;
    strobe(line_dp, ~line_dp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic restart_packet();
    @(negedge clk);
    rcving = 1'b0;
    repeat (2) @(negedge clk);
    rcving  = 1'b1;
    line_dp = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (d_orig !== 1'b1) begin errors++; $display("FAIL reset_d_orig got %b exp 1", d_orig); end
    checks++; if (stuff_skip !== 1'b0) begin errors++; $display("FAIL reset_stuff_skip got %b exp 0", stuff_skip); end
    checks++; if (stuff_err !== 1'b0) begin errors++; $display("FAIL reset_stuff_err got %b exp 0", stuff_err); end
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b exp 0", eop); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid got %b exp 0", byte_valid); end
  endtask

  // D+ 1,0,0,1,1 starting from J (prev_dp=1) decodes to 1,0,1,0,1
  task automatic test_decode();
    logic [4:0] dp_seq;
    logic [4:0] exp_seq;
    dp_seq  = 5'b11001;
    exp_seq = 5'b10101;
    restart_packet();
    for (int i = 0; i < 5; i++) begin
      strobe(dp_seq[i], ~dp_seq[i]);
      checks++;
      if (d_orig !== exp_seq[i]) begin
        errors++; $display("FAIL decode_bit%0d got %b exp %b", i, d_orig, exp_seq[i]);
      end
    end
  endtask

  task automatic test_byte();
    int bv0;
    restart_packet();
    bv0 = bv_cnt;
    send_byte(8'hA5);
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL byte_valid_pulse got %b exp 1", byte_valid); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL byte_rx_data got %h exp a5", rx_data); end
    repeat (3) @(negedge clk);
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL byte_valid_low got %b exp 0", byte_valid); end
    checks++; if (bv_cnt - bv0 !== 1) begin errors++; $display("FAIL byte_valid_count got %0d exp 1", bv_cnt - bv0); end
  endtask

  task automatic test_stuff();
    int bv0, sk0, er0;
    restart_packet();
    bv0 = bv_cnt; sk0 = skip_cnt; er0 = err_cnt;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    send_bit(1'b0);
    checks++; if (stuff_skip !== 1'b1) begin errors++; $display("FAIL stuff_skip_pulse got %b exp 1", stuff_skip); end
    checks++; if (bv_cnt - bv0 !== 0) begin errors++; $display("FAIL stuff_early_byte got %0d exp 0", bv_cnt - bv0); end
    send_bit(1'b0);
    send_bit(1'b0);
    repeat (2) @(negedge clk);
    checks++; if (skip_cnt - sk0 !== 1) begin errors++; $display("FAIL stuff_skip_count got %0d exp 1", skip_cnt - sk0); end
    checks++; if (bv_cnt - bv0 !== 1) begin errors++; $display("FAIL stuff_byte_count got %0d exp 1", bv_cnt - bv0); end
    checks++; if (rx_data !== 8'h3F) begin errors++; $display("FAIL stuff_rx_data got %h exp 3f", rx_data); end
    checks++; if (err_cnt - er0 !== 0) begin errors++; $display("FAIL stuff_no_err got %0d exp 0", err_cnt - er0); end
  endtask

  task automatic test_stuff_err();
    int bv0, er0;
    restart_packet();
    bv0 = bv_cnt; er0 = err_cnt;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    checks++; if (stuff_err !== 1'b1) begin errors++; $display("FAIL stuff_err_pulse got %b exp 1", stuff_err); end
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (2) @(negedge clk);
    checks++; if (err_cnt - er0 !== 1) begin errors++; $display("FAIL stuff_err_count got %0d exp 1", err_cnt - er0); end
    checks++; if (bv_cnt - bv0 !== 0) begin errors++; $display("FAIL err_no_byte got %0d exp 0", bv_cnt - bv0); end
    checks++; if (rx_data !== 8'h3F) begin errors++; $display("FAIL err_rx_hold got %h exp 3f", rx_data); end
    restart_packet();
    send_byte(8'h5A);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL err_recover got %h exp 5a", rx_data); end
  endtask

  // Bits 1,0,1, SE0 x2, J (decodes 0 after line at K), then 1,1,0,1 -> 0xB5
  task automatic test_eop();
    int bv0;
    restart_packet();
    bv0 = bv_cnt;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    strobe(1'b0, 1'b0);
    checks++; if (eop !== 1'b1) begin errors++; $display("FAIL eop_first got %b exp 1", eop); end
    strobe(1'b0, 1'b0);
    checks++; if (eop !== 1'b1) begin errors++; $display("FAIL eop_second got %b exp 1", eop); end
    line_dp = 1'b1;
    strobe(1'b1, 1'b0);
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL eop_clear got %b exp 0", eop); end
    checks++; if (d_orig !== 1'b0) begin errors++; $display("FAIL eop_j_decode got %b exp 0", d_orig); end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    checks++; if (bv_cnt - bv0 !== 0) begin errors++; $display("FAIL eop_bitcnt_early got %0d exp 0", bv_cnt - bv0); end
    send_bit(1'b1);
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL eop_byte_valid got %b exp 1", byte_valid); end
    checks++; if (rx_data !== 8'hB5) begin errors++; $display("FAIL eop_rx_data got %h exp b5", rx_data); end
  endtask

  task automatic test_clear_midbyte();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    strobe(1'b0, 1'b0);
    @(negedge clk);
    rcving = 1'b0;
    @(negedge clk);
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL clear_eop got %b exp 0", eop); end
    checks++; if (rx_data !== 8'hB5) begin errors++; $display("FAIL clear_rx_hold got %h exp b5", rx_data); end
    rcving  = 1'b1;
    line_dp = 1'b1;
    send_byte(8'hC3);
    checks++; if (rx_data !== 8'hC3 || byte_valid !== 1'b1) begin
      errors++; $display("FAIL clear_reassemble got %h/%b exp c3/1", rx_data, byte_valid);
    end
  endtask

  task automatic test_simul_clear();
    restart_packet();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    d_plus_sync = 1'b0; d_minus_sync = 1'b0;
    shift_enable = 1'b1; rcving = 1'b0;
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL simul_clear_eop got %b exp 0", eop); end
    @(negedge clk);
    rcving  = 1'b1;
    line_dp = 1'b1;
    send_byte(8'h81);
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL simul_clear_byte got %h exp 81", rx_data); end
  endtask

  task automatic test_back_to_back();
    int bv0;
    restart_packet();
    bv0 = bv_cnt;
    send_byte(8'h12);
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL b2b_first got %h exp 12", rx_data); end
    send_byte(8'h34);
    checks++; if (rx_data !== 8'h34) begin errors++; $display("FAIL b2b_second got %h exp 34", rx_data); end
    repeat (2) @(negedge clk);
    checks++; if (bv_cnt - bv0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", bv_cnt - bv0); end
  endtask

  task automatic test_async_reset();
    restart_packet();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    strobe(1'b0, 1'b0);
    #3;
    n_rst = 1'b0;
    #1;
    checks++; if (eop !== 1'b0 || d_orig !== 1'b1 || rx_data !== 8'h00 || byte_valid !== 1'b0 ||
                  stuff_skip !== 1'b0 || stuff_err !== 1'b0) begin
      errors++; $display("FAIL async_reset got eop=%b d_orig=%b rx=%h bv=%b exp 0/1/00/0", eop, d_orig, rx_data, byte_valid);
    end
    @(negedge clk);
    n_rst   = 1'b1;
    line_dp = 1'b1;
    send_byte(8'h69);
    checks++; if (rx_data !== 8'h69) begin errors++; $display("FAIL post_reset_byte got %h exp 69", rx_data); end
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    n_rst = 1'b1;
    @(negedge clk);
    test_decode();
    test_byte();
    test_stuff();
    test_stuff_err();
    test_eop();
    test_clear_midbyte();
    test_simul_clear();
    test_back_to_back();
    test_async_reset();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
